ext_bus_arb: RTL

Two-requester arbiter and access sequencer for the memory-mapped external bus (addresses 0xC000–0xFFFF). It sits between the CPU's external data port and a second master (DMA/debug) on one side, and the shared external peripheral bus on the other. It grants one access at a time using round-robin, drives the bus strobes for a programmable number of wait states plus a ready handshake, and returns read data with a done/err pulse.

---
 rtl/ext_bus_pkg.sv | 15 +
 rtl/rr_arb2.sv | 20 ++
 rtl/ext_bus_arb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external peripheral bus arbiter.
package ext_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] ERR_RDATA = 16'hDEAD;
  localparam logic [3:0] MMIO_BASE = 4'hC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision; the last_grant history flop lives in the caller.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1;
    end
  end

endmodule

// File: rtl/ext_bus_arb.sv
// Arbitrates two masters onto the external bus and sequences each access
// through wait states, a ready handshake and a ready timeout.
module ext_bus_arb
  import ext_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_re,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_re,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic              bus_re,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rdy
);

  state_t            state;
  state_t            next_state;
  logic              req0;
  logic              req1;
  logic              grant_valid;
  logic              grant_id;
  logic              last_grant;
  logic              owner;
  logic              op_we;
  logic              err_flag;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [3:0]        ws_cnt;
  logic [7:0]        to_cnt;
  logic              ws_zero;
  logic              to_zero;

  assign req0       = req0_re | req0_we;
  assign req1       = req1_re | req1_we;
  assign ws_zero    = (ws_cnt == 4'd0);
  assign to_zero    = (to_cnt == 8'd0);
  assign bus_addr   = lat_addr;
  assign bus_wdata  = lat_wdata;
  assign req0_rdata = rdata0;
  assign req1_rdata = rdata1;

  rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        if (ws_zero && (bus_rdy || to_zero)) begin
          next_state = DONE;
        end else begin
          next_state = ACCESS;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and completion flags decode only from state and latched registers.
  always_comb begin
    bus_re    = 1'b0;
    bus_we    = 1'b0;
    req0_done = 1'b0;
    req1_done = 1'b0;
    case (state)
      ACCESS: begin
        bus_re = ~op_we;
        bus_we = op_we;
      end
      DONE: begin
        req0_done = ~owner;
        req1_done = owner;
      end
      default: begin
        bus_re = 1'b0;
      end
    endcase
    req0_err = req0_done & err_flag;
    req1_err = req1_done & err_flag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_we      <= 1'b0;
      err_flag   <= 1'b0;
      lat_addr   <= 16'h0000;
      lat_wdata  <= 16'h0000;
      rdata0     <= 16'h0000;
      rdata1     <= 16'h0000;
      ws_cnt     <= 4'd0;
      to_cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_id;
            op_we     <= grant_id ? req1_we : req0_we;
            lat_addr  <= grant_id ? req1_addr : req0_addr;
            lat_wdata <= grant_id ? req1_wdata : req0_wdata;
            ws_cnt    <= 4'(WAIT_STATES);
            to_cnt    <= 8'(TIMEOUT);
            // History only moves on contention, so a lone requester cannot steal the next tie.
            if (req0 && req1) begin
              last_grant <= grant_id;
            end
          end
        end
        ACCESS: begin
          if (!ws_zero) begin
            ws_cnt <= ws_cnt - 4'd1;
          end else if (bus_rdy) begin
            if (!op_we && owner) begin
              rdata1 <= bus_rdata;
            end else if (!op_we) begin
              rdata0 <= bus_rdata;
            end
          end else if (to_zero) begin
            err_flag <= 1'b1;
            if (owner) begin
              rdata1 <= ERR_RDATA;
            end else begin
              rdata0 <= ERR_RDATA;
            end
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
        end
        DONE: begin
          err_flag <= 1'b0;
        end
        default: begin
          err_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule
